kyber_exchange_top: RTL and testbench

- Top-level sequencer for a Kyber-style key exchange between an on-chip server (key-generation/decapsulation side) and an on-chip client (encapsulation side).
- One `start` pulse runs the whole sequence:
  - server "key-generates" and streams a public key to the client;
  - client "encrypts" and streams a ciphertext back.
- Both streams appear on output ports for capture.
- Arithmetic cores are abstracted as fixed-latency stages with deterministic xorshift32 payloads, so the handshake/framing can be built and verified standalone.

---
 rtl/kyber_exchange_top.sv | 203 ++++++++++++++++++++
 tb/tb_kyber_exchange_top.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/kyber_exchange_top.sv
// Kyber-style key exchange sequencer: server keygen/pk stream, client ct stream.
// Arithmetic cores are fixed-latency stand-ins with xorshift32 payloads.
module kyber_exchange_top #(
  parameter int          KEYGEN_LAT = 64,
  parameter int          ENC_LAT    = 64,
  parameter int          DEC_LAT    = 64,
  parameter logic [31:0] SEED       = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  k,
  output logic        ready_pk,
  output logic        ready_c,
  output logic        req_pk,
  output logic        req_c,
  output logic        valid_server,
  output logic        valid_client,
  output logic [31:0] dout_server,
  output logic [31:0] dout_client
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYGEN, S_PKRDY, S_PKOUT, S_WAITCT, S_DEC
  } s_state_t;

  typedef enum logic [2:0] {
    C_IDLE, C_PKIN, C_ENC, C_CTRDY, C_CTOUT
  } c_state_t;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  s_state_t    s_st, s_nx;
  c_state_t    c_st, c_nx;
  logic [2:0]  k_q;
  logic [15:0] pkw, ctw;
  logic [15:0] sc, sc_d, cc, cc_d;
  logic [31:0] sx, sx_d, cx, cx_d;
  logic [31:0] acc, acc_d, acc_nx;
  logic        rpk_d, rqc_d, vs_d;
  logic        rc_d, rqp_d, vc_d;
  logic [31:0] ds_d, dc_d;
  logic        k_ok, accept;

  assign k_ok   = (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
  assign accept = start && k_ok && (s_st == S_IDLE) && (c_st == C_IDLE);
  assign acc_nx = acc ^ dout_server;

  always_comb begin
    pkw = 16'd8 + 16'd96 * {13'd0, k_q};
    ctw = 16'd192;
    unique case (1'b1)
      (k_q == 3'd3): ctw = 16'd272;
      (k_q == 3'd4): ctw = 16'd392;
      default:       ctw = 16'd192;
    endcase
  end

  always_comb begin
    s_nx  = s_st;
    sc_d  = sc;
    sx_d  = sx;
    rpk_d = ready_pk;
    rqc_d = 1'b0;
    vs_d  = 1'b0;
    ds_d  = dout_server;
    unique case (s_st)
      S_IDLE: if (accept) begin
        s_nx = S_KEYGEN;
        sc_d = '0;
        sx_d = SEED;
      end
      S_KEYGEN: if (sc == 16'(KEYGEN_LAT)) begin
        rpk_d = 1'b1;
        s_nx  = S_PKRDY;
      end else sc_d = sc + 16'd1;
      S_PKRDY: if (req_pk) begin
        rpk_d = 1'b0;
        vs_d  = 1'b1;
        ds_d  = xs32(sx);
        sx_d  = xs32(sx);
        sc_d  = 16'd1;
        s_nx  = S_PKOUT;
      end
      S_PKOUT: if (sc == pkw) begin
        sc_d = '0;
        s_nx = S_WAITCT;
      end else begin
        vs_d = 1'b1;
        ds_d = xs32(sx);
        sx_d = xs32(sx);
        sc_d = sc + 16'd1;
      end
      S_WAITCT: begin
        rqc_d = ready_c && !req_c;
        if (valid_client) begin
          if (sc == ctw - 16'd1) begin
            sc_d = '0;
            s_nx = S_DEC;
          end else sc_d = sc + 16'd1;
        end
      end
      S_DEC: if (sc == 16'(DEC_LAT)) s_nx = S_IDLE;
             else sc_d = sc + 16'd1;
      default: s_nx = S_IDLE;
    endcase
  end

  // Client seeds its generator from the XOR of every pk word it absorbed.
  always_comb begin
    c_nx  = c_st;
    cc_d  = cc;
    cx_d  = cx;
    acc_d = acc;
    rc_d  = ready_c;
    rqp_d = 1'b0;
    vc_d  = 1'b0;
    dc_d  = dout_client;
    unique case (c_st)
      C_IDLE: if (accept) begin
        c_nx  = C_PKIN;
        cc_d  = '0;
        acc_d = '0;
      end
      C_PKIN: begin
        rqp_d = ready_pk && !req_pk;
        if (valid_server) begin
          acc_d = acc_nx;
          if (cc == pkw - 16'd1) begin
            cc_d = '0;
            cx_d = (acc_nx == '0) ? 32'd1 : acc_nx;
            c_nx = C_ENC;
          end else cc_d = cc + 16'd1;
        end
      end
      C_ENC: if (cc == 16'(ENC_LAT - 1)) begin
        rc_d = 1'b1;
        c_nx = C_CTRDY;
      end else cc_d = cc + 16'd1;
      C_CTRDY: if (req_c) begin
        rc_d = 1'b0;
        vc_d = 1'b1;
        dc_d = xs32(cx);
        cx_d = xs32(cx);
        cc_d = 16'd1;
        c_nx = C_CTOUT;
      end
      C_CTOUT: if (cc == ctw) c_nx = C_IDLE;
      else begin
        vc_d = 1'b1;
        dc_d = xs32(cx);
        cx_d = xs32(cx);
        cc_d = cc + 16'd1;
      end
      default: c_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_st         <= S_IDLE;
      c_st         <= C_IDLE;
      k_q          <= '0;
      sc           <= '0;
      cc           <= '0;
      sx           <= '0;
      cx           <= '0;
      acc          <= '0;
      ready_pk     <= 1'b0;
      ready_c      <= 1'b0;
      req_pk       <= 1'b0;
      req_c        <= 1'b0;
      valid_server <= 1'b0;
      valid_client <= 1'b0;
      dout_server  <= '0;
      dout_client  <= '0;
    end else begin
      s_st         <= s_nx;
      c_st         <= c_nx;
      if (accept) k_q <= k;
      sc           <= sc_d;
      cc           <= cc_d;
      sx           <= sx_d;
      cx           <= cx_d;
      acc          <= acc_d;
      ready_pk     <= rpk_d;
      ready_c      <= rc_d;
      req_pk       <= rqp_d;
      req_c        <= rqc_d;
      valid_server <= vs_d;
      valid_client <= vc_d;
      dout_server  <= ds_d;
      dout_client  <= dc_d;
    end
  end

endmodule

// File: tb/tb_kyber_exchange_top.sv
// Directed bench for kyber_exchange_top: timing, stream framing, payloads.
// Vectors for k=2/3/4 plus reset, illegal-k and busy-start sequences.
module tb_kyber_exchange_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  k = 3'd0;
  logic        ready_pk, ready_c, req_pk, req_c;
  logic        valid_server, valid_client;
  logic [31:0] dout_server, dout_client;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kyber_exchange_top dut (
    .clk(clk), .rst(rst), .start(start), .k(k),
    .ready_pk(ready_pk), .ready_c(ready_c),
    .req_pk(req_pk), .req_c(req_c),
    .valid_server(valid_server), .valid_client(valid_client),
    .dout_server(dout_server), .dout_client(dout_client)
  );

  typedef struct {
    logic [2:0]  k;
    int          pkw;
    int          ctw;
    logic [31:0] first_pk;
    bit          mid_start;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ {x[18:0], 13'd0};
    y = y ^ {17'd0, y[31:17]};
    y = y ^ {y[26:0], 5'd0};
    return y;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic bit any_out();
    return ready_pk | ready_c | req_pk | req_c | valid_server |
           valid_client | (|dout_server) | (|dout_client);
  endfunction

  task automatic run(input vec_t v);
    int rpk_rise = -1, rpk_fall = -1, rqp_first = -1, rqp_n = 0;
    int vs_first = -1, vs_last = -1, vs_n = 0, vs_rises = 0;
    int rc_rise = -1, rc_fall = -1, rqc_first = -1, rqc_n = 0;
    int vc_first = -1, vc_n = 0, vc_rises = 0;
    int pk_bad = 0, ct_bad = 0;
    bit prev_vs = 0, prev_vc = 0;
    logic [31:0] sx = 32'h00000001;
    logic [31:0] cx = 32'd0;
    logic [31:0] acc = 32'd0;
    logic [31:0] first_pk = 32'd0;
    @(negedge clk);
    k = v.k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1;
      if (ready_pk && rpk_rise < 0) rpk_rise = c;
      if (!ready_pk && rpk_rise >= 0 && rpk_fall < 0) rpk_fall = c;
      if (req_pk) begin
        rqp_n++;
        if (rqp_first < 0) rqp_first = c;
      end
      if (valid_server) begin
        if (!prev_vs) vs_rises++;
        if (vs_first < 0) begin
          vs_first = c;
          first_pk = dout_server;
        end
        vs_last = c;
        vs_n++;
        sx = step(sx);
        acc = acc ^ sx;
        if (dout_server !== sx) pk_bad++;
      end
      if (ready_c && rc_rise < 0) rc_rise = c;
      if (!ready_c && rc_rise >= 0 && rc_fall < 0) rc_fall = c;
      if (req_c) begin
        rqc_n++;
        if (rqc_first < 0) rqc_first = c;
      end
      if (valid_client) begin
        if (!prev_vc) vc_rises++;
        if (vc_first < 0) begin
          vc_first = c;
          cx = (acc == 32'd0) ? 32'd1 : acc;
        end
        vc_n++;
        cx = step(cx);
        if (dout_client !== cx) ct_bad++;
      end
      prev_vs = valid_server;
      prev_vc = valid_client;
      start = v.mid_start && (c == 200);
      if (start) k = 3'd4;
    end
    start = 1'b0;
    chk($sformatf("k%0d ready_pk_rise", v.k), rpk_rise, 65);
    chk($sformatf("k%0d req_pk_cycle", v.k), rqp_first, 66);
    chk($sformatf("k%0d req_pk_width", v.k), rqp_n, 1);
    chk($sformatf("k%0d pk_first_cycle", v.k), vs_first, 67);
    chk($sformatf("k%0d ready_pk_fall", v.k), rpk_fall, 67);
    chk($sformatf("k%0d pk_count", v.k), vs_n, v.pkw);
    chk($sformatf("k%0d pk_gapless", v.k), vs_rises, 1);
    chk($sformatf("k%0d pk_first_word", v.k), first_pk, v.first_pk);
    chk($sformatf("k%0d pk_words", v.k), pk_bad, 0);
    chk($sformatf("k%0d pk_hold", v.k), dout_server, sx);
    chk($sformatf("k%0d ready_c_rise", v.k), rc_rise, vs_last + 65);
    chk($sformatf("k%0d req_c_cycle", v.k), rqc_first, rc_rise + 1);
    chk($sformatf("k%0d req_c_width", v.k), rqc_n, 1);
    chk($sformatf("k%0d ct_first_cycle", v.k), vc_first, rc_rise + 2);
    chk($sformatf("k%0d ready_c_fall", v.k), rc_fall, vc_first);
    chk($sformatf("k%0d ct_count", v.k), vc_n, v.ctw);
    chk($sformatf("k%0d ct_gapless", v.k), vc_rises, 1);
    chk($sformatf("k%0d ct_words", v.k), ct_bad, 0);
    chk($sformatf("k%0d ct_hold", v.k), dout_client, cx);
  endtask

  initial begin
    vecs[0] = '{k: 3'd4, pkw: 392, ctw: 392, first_pk: 32'h00042021, mid_start: 1'b0};
    vecs[1] = '{k: 3'd2, pkw: 200, ctw: 192, first_pk: 32'h00042021, mid_start: 1'b0};
    vecs[2] = '{k: 3'd3, pkw: 296, ctw: 272, first_pk: 32'h00042021, mid_start: 1'b1};

    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", any_out(), 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 3; i++) run(vecs[i]);

    // Illegal security levels must not start anything.
    for (int b = 0; b < 2; b++) begin
      int act = 0;
      @(negedge clk);
      k = (b == 0) ? 3'd5 : 3'd1;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk);
        #1 if (any_out() && (ready_pk || valid_server || req_pk)) act++;
      end
      chk($sformatf("bad_k%0d_ignored", k), act, 0);
    end

    // Reset in the middle of the pk stream.
    begin
      int act = 0;
      @(negedge clk);
      k = 3'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      #1 chk("mid_stream_valid", valid_server, 1);
      rst = 1'b0;
      #1 chk("async_reset_outputs", any_out(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      for (int c = 0; c < 120; c++) begin
        @(posedge clk);
        #1 if (any_out()) act++;
      end
      chk("no_resume_after_reset", act, 0);
    end
    run(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
